// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared arbiter state encodings and tie-break helper
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;

    // Grant choice for the next cycle; tie_to1 decides only when both request.
    function automatic logic [1:0] arb_pick(input logic r0, input logic r1, input logic tie_to1);
        logic [1:0] nxt;
        if (r0 && r1) begin
            nxt = tie_to1 ? ST_GNT1 : ST_GNT0;
        end else if (r0) begin
            nxt = ST_GNT0;
        end else if (r1) begin
            nxt = ST_GNT1;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// rtl/mem_port_arbiter_mux.sv - 2:1 data mux, sel=0 passes in0
module mem_port_arbiter_mux #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] dout
);

    assign dout = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester shared port arbiter, round-robin ties
// (define ARB_FIXED_PRIO_EN for fixed priority to requester 0)
module mem_port_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             select,
    output logic             ack0,
    output logic             ack1
);

    import mem_port_arbiter_pkg::*;

    logic [1:0] state_q, state_d;
    logic       select_q, select_d;
    logic       ack0_c, ack1_c;
    logic       tie_to1;

`ifndef ARB_FIXED_PRIO_EN
    logic       last_gnt_q, last_gnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ack0_c   = (state_q == ST_GNT0) && req0 && out_ready;
        ack1_c   = (state_q == ST_GNT1) && req1 && out_ready;
`ifdef ARB_FIXED_PRIO_EN
        tie_to1  = 1'b0;
`else
        last_gnt_d = last_gnt_q;
        if (ack0_c) begin
            last_gnt_d = 1'b0;
        end else if (ack1_c) begin
            last_gnt_d = 1'b1;
        end
        // A just-acked requester yields the next tie; a withdrawal leaves history alone.
        tie_to1 = ~last_gnt_d;
`endif
        case (state_q)
            ST_IDLE: state_d = arb_pick(req0, req1, tie_to1);
            ST_GNT0: begin
                if (!req0 || out_ready) begin
                    state_d = arb_pick(req0, req1, tie_to1);
                end
            end
            ST_GNT1: begin
                if (!req1 || out_ready) begin
                    state_d = arb_pick(req0, req1, tie_to1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Select only moves on entering a grant, so it holds its last value through IDLE.
        if (state_d == ST_GNT1) begin
            select_d = 1'b1;
        end else if (state_d == ST_GNT0) begin
            select_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            select_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    assign out_valid = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign select    = select_q;
    assign ack0      = ack0_c;
    assign ack1      = ack1_c;

    mem_port_arbiter_mux #(
        .WIDTH(WIDTH)
    ) u_mux (
        .sel (select_q),
        .in0 (data0),
        .in1 (data1),
        .dout(out_data)
    );

endmodule
